// File: rtl/audio_nios_key_irq_host_pkg.sv
// Register map and FSM state type for the key-PIO interrupt host.
package audio_nios_key_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        StInitMask,
        StIdle,
        StRdEdge,
        StClrEdge,
        StRdLvl,
        StEmit
    } key_host_state_t;

endpackage

// File: rtl/audio_nios_key_irq_host_if.sv
// Avalon-MM link to the key PIO plus the valid/ready event channel to the control FSM.
interface audio_nios_key_irq_host_if #(
    parameter int unsigned KEY_W = 4
);

    logic [1:0]       avm_address;
    logic             avm_chipselect;
    logic             avm_write_n;
    logic [31:0]      avm_writedata;
    logic [31:0]      avm_readdata;
    logic             irq;
    logic             evt_valid;
    logic             evt_ready;
    logic [KEY_W-1:0] evt_edges;
    logic [KEY_W-1:0] evt_level;

    // Host side: drives the bus and produces events.
    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata, irq,
        output evt_valid, evt_edges, evt_level,
        input  evt_ready
    );

    // Responder/consumer side.
    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata, irq,
        input  evt_valid, evt_edges, evt_level,
        output evt_ready
    );

endinterface

// File: rtl/audio_nios_key_irq_host.sv
// Services the key PIO interrupt: programs the mask, reads and clears edge capture,
// samples key levels and hands one event per interrupt to the consumer.
module audio_nios_key_irq_host
    import audio_nios_key_pkg::*;
#(
    parameter int unsigned      KEY_W    = 4,
    parameter logic [KEY_W-1:0] KEY_MASK = 4'hF,
    parameter int unsigned      RD_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    audio_nios_key_irq_host_if.master   bus,
    output logic                        init_done
);

    localparam int unsigned      CNT_W     = $clog2(RD_LAT + 2);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RD_LAT);
    localparam logic [31:0]      MASK_WORD = 32'(KEY_MASK);

    key_host_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       addr_q, addr_d;
    logic             wr_q, wr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [KEY_W-1:0] edges_q, edges_d;
    logic [KEY_W-1:0] level_q, level_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [KEY_W-1:0] rd_key;
    logic             unused_rd_hi;

    assign rd_key       = bus.avm_readdata[KEY_W-1:0];
    assign unused_rd_hi = ^bus.avm_readdata[31:KEY_W];

    // Bus registers are loaded with the cycle the next state will present.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        wdata_d = '0;
        edges_d = edges_q;
        level_d = level_q;
        valid_d = valid_q;
        done_d  = done_q;
        unique case (state_q)
            StInitMask: begin
                if (!wr_q) begin
                    wr_d    = 1'b1;
                    addr_d  = ADDR_MASK;
                    wdata_d = MASK_WORD;
                end else begin
                    state_d = StIdle;
                    addr_d  = ADDR_EDGE;
                    done_d  = 1'b1;
                end
            end
            StIdle: begin
                addr_d = ADDR_EDGE;
                if (bus.irq) begin
                    state_d = StRdEdge;
                    cnt_d   = CNT_LOAD;
                end
            end
            StRdEdge: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    edges_d = rd_key;
                    // Nothing captured: spurious interrupt, leave the responder alone.
                    if (rd_key == '0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StClrEdge;
                        wr_d    = 1'b1;
                    end
                end
            end
            StClrEdge: begin
                state_d = StRdLvl;
                cnt_d   = CNT_LOAD;
                addr_d  = ADDR_DATA;
            end
            StRdLvl: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    level_d = rd_key;
                    state_d = StEmit;
                    valid_d = 1'b1;
                    addr_d  = ADDR_EDGE;
                end
            end
            StEmit: begin
                if (bus.evt_ready) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StInitMask;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StInitMask;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            edges_q <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            edges_q <= edges_d;
            level_q <= level_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.avm_address    = addr_q;
    assign bus.avm_chipselect = wr_q;
    assign bus.avm_write_n    = ~wr_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.evt_valid      = valid_q;
    assign bus.evt_edges      = edges_q;
    assign bus.evt_level      = level_q;
    assign init_done          = done_q;

endmodule

// File: tb/tb_audio_nios_key_irq_host.sv
// Bench for the key-PIO interrupt host: RD_LAT=1 and RD_LAT=3 builds against a
// key-PIO responder model and a timeline model of the expected bus/event behaviour.
module tb_audio_nios_key_irq_host;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0]  press [2];
    logic [3:0]  keys [2];
    logic [1:0]  spur;
    logic [1:0]  ready;

    logic [1:0]  m_valid, m_cs, m_done, m_irq;
    logic [1:0]  m_addr [2];
    logic [3:0]  m_edges [2];
    logic [3:0]  m_level [2];

    int          wr_cnt [2] = '{0, 0};
    logic [1:0]  last_waddr [2];
    logic [31:0] last_wdata [2];
    int          ev_cnt [2] = '{0, 0};
    logic [7:0]  ev_log [2][8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : 3;

        audio_nios_key_irq_host_if #(.KEY_W(4)) bus ();
        logic init_done;

        audio_nios_key_irq_host #(
            .KEY_W   (4),
            .KEY_MASK(4'hF),
            .RD_LAT  (L)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .bus      (bus),
            .init_done(init_done)
        );

        // Key PIO responder: edge capture, irq mask, read pipeline of L cycles.
        logic [3:0]  edge_cap = '0;
        logic [3:0]  mask = '0;
        logic [31:0] rd_pipe [L];

        assign bus.irq          = (|(edge_cap & mask)) | spur[g];
        assign bus.evt_ready    = ready[g];
        assign bus.avm_readdata = rd_pipe[L-1];

        assign m_valid[g] = bus.evt_valid;
        assign m_cs[g]    = bus.avm_chipselect;
        assign m_done[g]  = init_done;
        assign m_irq[g]   = bus.irq;
        assign m_addr[g]  = bus.avm_address;
        assign m_edges[g] = bus.evt_edges;
        assign m_level[g] = bus.evt_level;

        always @(posedge clk) begin : p_resp
            logic [31:0] v;
            case (bus.avm_address)
                2'd0:    v = {28'd0, keys[g]};
                2'd2:    v = {28'd0, mask};
                2'd3:    v = {28'd0, edge_cap};
                default: v = 32'd0;
            endcase
            rd_pipe[0] <= 32'hABCD_E000 | v;
            for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
            if (bus.avm_chipselect && !bus.avm_write_n) begin
                wr_cnt[g]     <= wr_cnt[g] + 1;
                last_waddr[g] <= bus.avm_address;
                last_wdata[g] <= bus.avm_writedata;
                if (bus.avm_address == 2'd2) mask <= bus.avm_writedata[3:0];
                if (bus.avm_address == 2'd3) edge_cap <= press[g];
                else                         edge_cap <= edge_cap | press[g];
            end else begin
                edge_cap <= edge_cap | press[g];
            end
        end

        // Timeline model: mode 0 = after reset, 1 = idle, 2 = servicing (t = cycle index).
        int         mode = 0;
        int         t = 0;
        logic [3:0] x_edges = '0;
        logic [3:0] x_level = '0;

        always @(negedge clk) begin : p_cmp
            logic [1:0]  e_addr;
            logic        e_wr, e_valid, e_cmp_addr;
            logic [31:0] e_wd;
            if (reset) begin
                chk("rst_addr", 32'(bus.avm_address), 0);
                chk("rst_cs", 32'(bus.avm_chipselect), 0);
                chk("rst_wn", 32'(bus.avm_write_n), 1);
                chk("rst_wdata", bus.avm_writedata, 0);
                chk("rst_valid", 32'(bus.evt_valid), 0);
                chk("rst_edges", 32'(bus.evt_edges), 0);
                chk("rst_level", 32'(bus.evt_level), 0);
                chk("rst_done", 32'(init_done), 0);
                mode = 0;
                t = 0;
            end else begin
                e_wr = 1'b0; e_wd = '0; e_valid = 1'b0; e_cmp_addr = 1'b1; e_addr = 2'd3;
                if (mode == 0) begin
                    if (t == 0) e_addr = 2'd0;
                    else begin e_wr = 1'b1; e_addr = 2'd2; e_wd = 32'h0000_000F; end
                end else if (mode == 2) begin
                    if (t <= L + 1)          e_addr = 2'd3;
                    else if (t == L + 2)     e_wr = 1'b1;
                    else if (t <= 2 * L + 3) e_addr = 2'd0;
                    else begin e_valid = 1'b1; e_cmp_addr = 1'b0; end
                end
                chk("cs", 32'(bus.avm_chipselect), 32'(e_wr));
                chk("write_n", 32'(bus.avm_write_n), 32'(!e_wr));
                chk("wdata", bus.avm_writedata, e_wd);
                chk("valid", 32'(bus.evt_valid), 32'(e_valid));
                chk("init_done", 32'(init_done), 32'(mode != 0));
                if (e_cmp_addr) chk("addr", 32'(bus.avm_address), 32'(e_addr));
                if (e_valid) begin
                    chk("evt_edges", 32'(bus.evt_edges), 32'(x_edges));
                    chk("evt_level", 32'(bus.evt_level), 32'(x_level));
                end
                if (mode == 0) begin
                    if (t == 1) mode = 1;
                    else t = t + 1;
                end else if (mode == 1) begin
                    if (bus.irq) begin mode = 2; t = 1; end
                end else begin
                    if (t == 1) x_edges = edge_cap;
                    if (t == L + 3) x_level = keys[g];
                    if (t == L + 1 && x_edges == 4'd0) begin
                        mode = 1;
                    end else if (t >= 2 * L + 4) begin
                        if (ready[g]) begin
                            if (ev_cnt[g] < 8) ev_log[g][ev_cnt[g]] = {x_edges, x_level};
                            ev_cnt[g] = ev_cnt[g] + 1;
                            mode = 1;
                        end
                    end else begin
                        t = t + 1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        press = '{4'd0, 4'd0};
        keys  = '{4'd0, 4'd0};
        spur  = '0;
        ready = '0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(6);
        chk("init_wr_cnt", 32'(wr_cnt[0]), 1);
        chk("init_waddr", 32'(last_waddr[0]), 2);
        chk("init_wdata", last_wdata[0], 32'h0000_000F);
        chk("init_done_set", 32'(m_done[0]), 1);
        chk("init_wr_cnt_l3", 32'(wr_cnt[1]), 1);

        // Spurious irq: edge capture empty.
        spur[0] = 1'b1; tick(1); spur[0] = 1'b0;
        tick(10);
        chk("spur_no_write", 32'(wr_cnt[0]), 1);
        chk("spur_no_event", 32'(ev_cnt[0]), 0);
        chk("spur_valid", 32'(m_valid[0]), 0);

        // Single key press, consumer ready.
        keys[0] = 4'b1011; ready[0] = 1'b1;
        press[0] = 4'b0100; tick(1); press[0] = 4'd0;
        chk("press_irq", 32'(m_irq[0]), 1);
        n = 0;
        while (!m_valid[0] && n < 40) begin tick(1); n++; end
        chk("lat_l1", 32'(n), 6);
        tick(10);
        chk("press_ev_cnt", 32'(ev_cnt[0]), 1);
        chk("press_ev", 32'(ev_log[0][0]), 32'h4B);
        chk("press_wr_cnt", 32'(wr_cnt[0]), 2);

        // Backpressure with a second press arriving while the first event waits.
        ready[0] = 1'b0; keys[0] = 4'b0111;
        press[0] = 4'b1000; tick(1); press[0] = 4'd0;
        n = 0;
        while (!m_valid[0] && n < 40) begin tick(1); n++; end
        chk("bp_lat", 32'(n), 6);
        press[0] = 4'b0010; tick(1); press[0] = 4'd0;
        tick(20);
        chk("bp_hold_valid", 32'(m_valid[0]), 1);
        chk("bp_hold_edges", 32'(m_edges[0]), 32'h8);
        chk("bp_hold_level", 32'(m_level[0]), 32'h7);
        chk("bp_irq_pending", 32'(m_irq[0]), 1);
        chk("bp_ev_cnt_held", 32'(ev_cnt[0]), 1);
        ready[0] = 1'b1;
        tick(30);
        chk("bp_ev_cnt", 32'(ev_cnt[0]), 3);
        chk("bp_ev1", 32'(ev_log[0][1]), 32'h87);
        chk("bp_ev2", 32'(ev_log[0][2]), 32'h27);

        // Reset while reading levels.
        press[0] = 4'b0001; tick(1); press[0] = 4'd0;
        n = 0;
        while (m_addr[0] != 2'd0 && n < 40) begin tick(1); n++; end
        chk("rl_reached", 32'(n < 40), 1);
        reset = 1'b1;
        #1;
        chk("rl_valid", 32'(m_valid[0]), 0);
        chk("rl_cs", 32'(m_cs[0]), 0);
        chk("rl_level", 32'(m_level[0]), 0);
        chk("rl_done", 32'(m_done[0]), 0);
        tick(2);
        reset = 1'b0;
        tick(8);
        chk("rl_wr_cnt", 32'(wr_cnt[0]), 6);
        chk("rl_waddr", 32'(last_waddr[0]), 2);
        chk("rl_no_event", 32'(ev_cnt[0]), 3);
        chk("rl_valid_after", 32'(m_valid[0]), 0);
        chk("rl_done_after", 32'(m_done[0]), 1);

        // RD_LAT=3 build.
        keys[1] = 4'b1010; ready[1] = 1'b1;
        press[1] = 4'b0100; tick(1); press[1] = 4'd0;
        chk("l3_irq", 32'(m_irq[1]), 1);
        n = 0;
        while (!m_valid[1] && n < 40) begin tick(1); n++; end
        chk("lat_l3", 32'(n), 10);
        tick(10);
        chk("l3_ev_cnt", 32'(ev_cnt[1]), 1);
        chk("l3_ev", 32'(ev_log[1][0]), 32'h4A);
        chk("l3_wr_cnt", 32'(wr_cnt[1]), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_nios_key_irq_host.md
# audio_nios_key_irq_host

Avalon-MM host that services the 4-bit key PIO responder without a Nios II. It programs the responder's interrupt mask after reset, waits for the PIO `irq`, and reads the edge-capture register. It then clears that register by writing to it, samples the key levels, and hands one event to the audio control logic over a valid/ready interface. The block sits between the key PIO's s1 slave port and the fabric-side control FSM on the same clock.

## Interface
Parameters:
- `KEY_W`, 4: key count; matches responder data width.
- `KEY_MASK`, 4'hF: value written to irq_mask (addr 2) after reset.
- `RD_LAT`, 1: responder read latency in cycles; ≥1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, active-high; one clock, reset asynchronous and active-high.
- `avm_address`  out  2  responder register address.
- `avm_chipselect`  out  1  write qualifier.
- `avm_write_n`  out  1  active-low write strobe.
- `avm_writedata`  out  32  write data.
- `avm_readdata`  in  32  responder read data; only bits [KEY_W-1:0] are used.
- `irq`  in  1  responder interrupt (level).
- `evt_valid`  out  1  event available.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_edges`  out  KEY_W  captured falling-edge bits.
- `evt_level`  out  KEY_W  key levels sampled after the clear.
- `init_done`  out  1  mask has been programmed.

## Operation
- FSM states: INIT_MASK → IDLE → RD_EDGE → CLR_EDGE → RD_LVL → EMIT → IDLE.
- **INIT_MASK**
  - One write cycle: address 2, `chipselect`=1, `write_n`=0, writedata = zero-extended KEY_MASK.
  - Then `init_done`←1, which stays set until reset.
- **IDLE**
  - Bus idle: `chipselect`=0, `write_n`=1, address 3.
  - If `irq`=1, go to RD_EDGE.
- **RD_EDGE**
  - Hold address 3 for RD_LAT+1 cycles, with `chipselect`=0 and `write_n`=1.
  - Latch `avm_readdata[KEY_W-1:0]` into the edges register on the last cycle.
  - If the latched value is 0 (spurious irq), return to IDLE with no write and no event.
- **CLR_EDGE**
  - One write cycle to address 3, writedata = 0; the responder clears all capture bits.
- **RD_LVL**
  - Hold address 0 for RD_LAT+1 cycles.
  - Latch `avm_readdata[KEY_W-1:0]` into the level register.
- **EMIT**
  - `evt_valid`=1; `evt_edges` and `evt_level` stay stable until the handshake.
  - The handshake is `evt_valid`&&`evt_ready` on a rising clk edge. After it, `evt_valid`←0 and the FSM goes to IDLE.
  - `irq` is ignored while in EMIT. The responder keeps new edges latched, so none are lost, and `irq` is re-serviced from IDLE.
- **Known lossy window:** an edge captured by the responder between the RD_EDGE sample and the CLR_EDGE write is cleared unreported. This is accepted behaviour; keys are debounced upstream.
- **Write rule:** `avm_write_n`=0 only in INIT_MASK and CLR_EDGE. `avm_chipselect` equals ~`avm_write_n`.

## Timing
- **Reset values:**
  - `avm_address`=0, `avm_chipselect`=0, `avm_write_n`=1, `avm_writedata`=0.
  - `evt_valid`=0, `evt_edges`=0, `evt_level`=0, `init_done`=0.
  - State is INIT_MASK.
- **First write:** the first clk after reset deasserts is the INIT_MASK write; `init_done`=1 on the following cycle.
- **Registered outputs:** all bus outputs come from registers, with no combinational path from inputs.
- **Latency with RD_LAT=1**, irq sampled high in IDLE at cycle 0:
  - Cycles 1–2: RD_EDGE, sample at the end of cycle 2.
  - Cycle 3: CLR_EDGE.
  - Cycles 4–5: RD_LVL.
  - Cycle 6: `evt_valid`=1.
  - Irq-to-valid latency is 6 cycles, or 2·RD_LAT+4 in general.
- **Back-to-back:** `evt_ready` held at 1 gives one event per 7 cycles minimum under continuous irq.
- **Reset mid-operation:** the FSM aborts immediately and returns to INIT_MASK. Any pending event is dropped and the mask is rewritten.

## Structure
- **Package `audio_nios_key_pkg`:**
  - Register address constants ADDR_DATA=2'd0, ADDR_MASK=2'd2, ADDR_EDGE=2'd3.
  - State enum `key_host_state_t`.
- **Single module**, no sub-module. The RD_LAT wait counter is a `$clog2(RD_LAT+2)`-bit down-counter inside the FSM.

## Test plan
- **Reset release** → exactly one write to addr 2 with data 0x0000000F, then `init_done`=1; no further bus writes while `irq`=0.
- **Single key press:** responder model sets edge_capture=4'b0100 and raises irq → read addr 3, write addr 3, read addr 0 (levels 4'b1011) → `evt_valid` at cycle 6 with edges=4'b0100, level=4'b1011.
- **Spurious irq:** `irq` pulses with edge_capture=0 → addr 3 read, no write, no event, FSM back in IDLE.
- **Backpressure:** `evt_ready`=0 for 20 cycles while a second key press (bit 1) arrives → first event held stable; after accept, a second event with edges=4'b0010, none lost.
- **Reset during RD_LVL** → outputs return to reset values immediately; mask rewritten on release; no event emitted.
- **RD_LAT=3 build** → irq-to-valid is 10 cycles; address held 4 cycles per read.
